// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator pipeline (converter, evaluator, display).
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 16;
  localparam int unsigned CALC_DEPTH = 8;

  typedef enum logic [1:0] {
    TOK_NUM = 2'd0,
    TOK_OP  = 2'd1,
    TOK_END = 2'd2
  } tok_type_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK         = 2'd0,
    ERR_UNDERFLOW  = 2'd1,
    ERR_STACK_FULL = 2'd2,
    ERR_LEFTOVER   = 2'd3
  } err_e;

  // Raw operator code 3 is reserved and behaves as ADD.
  function automatic op_e decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_op = OP_SUB;
      2'd2:    decode_op = OP_MUL;
      default: decode_op = OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/postfix_evaluator_if.sv
// Token stream in / expression result out between converter, evaluator and display stage.
interface postfix_evaluator_if #(
  parameter int unsigned WIDTH = calc_pkg::CALC_WIDTH
);

  logic             tok_valid;
  logic             tok_ready;
  logic [1:0]       tok_type;
  logic [1:0]       tok_op;
  logic [WIDTH-1:0] tok_num;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       err;
  logic             ovf;

  modport master (
    output tok_valid, tok_type, tok_op, tok_num,
    input  tok_ready, done, result, err, ovf
  );

  modport slave (
    input  tok_valid, tok_type, tok_op, tok_num,
    output tok_ready, done, result, err, ovf
  );

endinterface

// File: rtl/calc_stack.sv
// Operand LIFO with push, atomic pop-two-push-one and clear. DEPTH must be at least 2.
module calc_stack #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned DW    = $clog2(DEPTH + 1),
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop2_push,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [DW-1:0]    depth
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    cnt;

  // Clear wins, then the binary op, then a literal push; illegal requests are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (pop2_push && cnt >= DW'(2)) begin
      mem[AW'(cnt - DW'(2))] <= push_data;
      cnt                    <= cnt - DW'(1);
    end else if (push && cnt < DW'(DEPTH)) begin
      mem[AW'(cnt)] <= push_data;
      cnt           <= cnt + DW'(1);
    end
  end

  assign top    = (cnt >= DW'(1)) ? mem[AW'(cnt - DW'(1))] : '0;
  assign second = (cnt >= DW'(2)) ? mem[AW'(cnt - DW'(2))] : '0;
  assign depth  = cnt;

endmodule

// File: rtl/postfix_evaluator.sv
// Evaluates an RPN token stream on an operand stack; one signed result plus status per END.
module postfix_evaluator
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH,
  parameter int unsigned DEPTH = CALC_DEPTH
) (
  input logic               clk,
  input logic               rst,
  postfix_evaluator_if.slave bus
);

  localparam int unsigned DW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_EXEC   = 2'd1,
    S_FLUSH  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e                   state;
  op_e                      op_q;
  err_e                     err_q;
  logic                     ovf_acc;

  logic [WIDTH-1:0]         top;
  logic [WIDTH-1:0]         second;
  logic [DW-1:0]            depth;
  logic                     push;
  logic                     pop2_push;
  logic                     clear;
  logic                     is_num;
  logic                     is_op;
  logic                     is_end;

  logic signed [WIDTH-1:0]   opa;
  logic signed [WIDTH-1:0]   opb;
  logic signed [WIDTH:0]     sum;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   alu_res;
  logic                      alu_ovf;

  // Reserved token type 3 decodes as END.
  assign is_num = (bus.tok_type == TOK_NUM);
  assign is_op  = (bus.tok_type == TOK_OP);
  assign is_end = !is_num && !is_op;

  assign push      = (state == S_ACCEPT) && bus.tok_valid && is_num && (depth < DW'(DEPTH));
  assign pop2_push = (state == S_EXEC);
  assign clear     = (state == S_FINISH);

  assign bus.tok_ready = !rst && ((state == S_ACCEPT) || (state == S_FLUSH));

  calc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop2_push (pop2_push),
    .clear     (clear),
    .push_data (pop2_push ? WIDTH'(alu_res) : bus.tok_num),
    .top       (top),
    .second    (second),
    .depth     (depth)
  );

  assign opa = $signed(second);
  assign opb = $signed(top);

  // a op b with a the deeper operand; overflow when the exact value does not fit WIDTH bits.
  always_comb begin
    sum     = '0;
    prod    = '0;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_SUB: begin
        sum     = (WIDTH+1)'(opa) - (WIDTH+1)'(opb);
        alu_res = sum[WIDTH-1:0];
        alu_ovf = (sum[WIDTH] != sum[WIDTH-1]);
      end
      OP_MUL: begin
        prod    = (2*WIDTH)'(opa) * (2*WIDTH)'(opb);
        alu_res = prod[WIDTH-1:0];
        alu_ovf = (prod != (2*WIDTH)'(alu_res));
      end
      default: begin
        sum     = (WIDTH+1)'(opa) + (WIDTH+1)'(opb);
        alu_res = sum[WIDTH-1:0];
        alu_ovf = (sum[WIDTH] != sum[WIDTH-1]);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_ACCEPT;
      op_q       <= OP_ADD;
      err_q      <= ERR_OK;
      ovf_acc    <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.err    <= ERR_OK;
      bus.ovf    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_ACCEPT: begin
          if (bus.tok_valid) begin
            if (is_num) begin
              if (depth == DW'(DEPTH)) begin
                err_q <= ERR_STACK_FULL;
                state <= S_FLUSH;
              end
            end else if (is_op) begin
              if (depth < DW'(2)) begin
                err_q <= ERR_UNDERFLOW;
                state <= S_FLUSH;
              end else begin
                op_q  <= decode_op(bus.tok_op);
                state <= S_EXEC;
              end
            end else begin
              bus.done <= 1'b1;
              bus.ovf  <= ovf_acc;
              if (depth == DW'(1)) begin
                bus.result <= top;
                bus.err    <= ERR_OK;
              end else begin
                bus.result <= '0;
                bus.err    <= (depth == '0) ? ERR_UNDERFLOW : ERR_LEFTOVER;
              end
              state <= S_FINISH;
            end
          end
        end
        S_EXEC: begin
          ovf_acc <= ovf_acc | alu_ovf;
          state   <= S_ACCEPT;
        end
        // First latched error is reported; everything up to END is dropped.
        S_FLUSH: begin
          if (bus.tok_valid && is_end) begin
            bus.done   <= 1'b1;
            bus.result <= '0;
            bus.err    <= err_q;
            bus.ovf    <= ovf_acc;
            state      <= S_FINISH;
          end
        end
        default: begin
          ovf_acc <= 1'b0;
          err_q   <= ERR_OK;
          state   <= S_ACCEPT;
        end
      endcase
    end
  end

endmodule
